// File: rtl/mem_c_data_buffer.sv
// mem_c_data_buffer
//   Two-slot ping-pong buffer for C result tiles. The array side writes one
//   full result row per accepted beat. The bus side drains complete tiles
//   one bus word at a time, in C address-generator order: row fastest, then
//   column chunk.
//
//   Handshakes:
//     write: a row is taken on a rising edge when row_valid & row_ready.
//            row_ready depends on registered state only.
//     read : data_o is show-ahead. A word is consumed on a rising edge when
//            fifo_incr & ~fifo_empty. fifo_incr while empty is ignored.
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset (pointers and flags only)
//   clear_i     synchronous flush of pointers and flags
//   row_valid   row_data holds one valid result row
//   row_ready   buffer accepts a row this cycle
//   row_data    one result row; element j at [j*DW*8 +: DW*8]
//   fifo_empty  no complete tile is available to drain
//   fifo_incr   pop the current output word
//   data_o      current output word
//   tiles_held  number of full tile slots (0..2)
//
// ARRAY_HEIGHT and ARRAY_WIDTH/EPW are assumed to be powers of two >= 2.
module mem_c_data_buffer #(
  parameter int BUS_WIDTH_BYTES  = 32,
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ARRAY_HEIGHT     = 4,
  parameter int ARRAY_WIDTH      = 32
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      clear_i,
  input  logic                                      row_valid,
  output logic                                      row_ready,
  input  logic [ARRAY_WIDTH*DATA_WIDTH_BYTES*8-1:0] row_data,
  output logic                                      fifo_empty,
  input  logic                                      fifo_incr,
  output logic [BUS_WIDTH_BYTES*8-1:0]              data_o,
  output logic [1:0]                                tiles_held
);

  localparam int EPW   = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
  localparam int WPR   = ARRAY_WIDTH / EPW;
  localparam int TW    = ARRAY_HEIGHT * WPR;
  localparam int ROW_W = ARRAY_WIDTH * DATA_WIDTH_BYTES * 8;
  localparam int BUS_W = BUS_WIDTH_BYTES * 8;
  localparam int RW    = $clog2(ARRAY_HEIGHT);
  localparam int WW    = $clog2(TW);

  // Slot storage: never reset, contents are don't-care until a tile is full.
  logic [ROW_W-1:0] mem_q [2][ARRAY_HEIGHT];

  logic          wr_sel_q, wr_sel_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic          rd_sel_q, rd_sel_d;
  logic [WW-1:0] rd_word_q, rd_word_d;
  logic [1:0]    full_q, full_d;

  logic          wr_fire;
  logic          rd_fire;
  logic [RW-1:0] rd_row;
  logic [WW-1:0] rd_chunk;
  logic [ROW_W-1:0] rd_row_data;

  assign row_ready  = ~full_q[wr_sel_q];
  assign fifo_empty = ~full_q[rd_sel_q];
  assign tiles_held = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  assign wr_fire = row_valid & row_ready;
  assign rd_fire = fifo_incr & ~fifo_empty;

  // The low bits of rd_word pick the row and the high bits pick the chunk.
  // This is the same as row = rd_word mod H and chunk = rd_word / H.
  assign rd_row      = rd_word_q[RW-1:0];
  assign rd_chunk    = rd_word_q >> RW;
  assign rd_row_data = mem_q[rd_sel_q][rd_row];
  assign data_o      = rd_row_data[rd_chunk*BUS_W +: BUS_W];

  // Next-state logic for pointers and full flags.
  // When write and read both fire, they always touch different slots.
  // The write side only sets an empty slot. The read side only clears a
  // full slot. So both updates can safely take effect on the same edge.
  always_comb begin
    wr_sel_d  = wr_sel_q;
    wr_row_d  = wr_row_q;
    rd_sel_d  = rd_sel_q;
    rd_word_d = rd_word_q;
    full_d    = full_q;
    if (clear_i) begin
      wr_sel_d  = 1'b0;
      wr_row_d  = '0;
      rd_sel_d  = 1'b0;
      rd_word_d = '0;
      full_d    = '0;
    end else begin
      if (wr_fire) begin
        wr_row_d = wr_row_q + RW'(1);
        if (wr_row_q == RW'(ARRAY_HEIGHT - 1)) begin
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = ~wr_sel_q;
        end
      end
      if (rd_fire) begin
        if (rd_word_q == WW'(TW - 1)) begin
          rd_word_d        = '0;
          full_d[rd_sel_q] = 1'b0;
          rd_sel_d         = ~rd_sel_q;
        end else begin
          rd_word_d = rd_word_q + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_q  <= 1'b0;
      wr_row_q  <= '0;
      rd_sel_q  <= 1'b0;
      rd_word_q <= '0;
      full_q    <= '0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      wr_row_q  <= wr_row_d;
      rd_sel_q  <= rd_sel_d;
      rd_word_q <= rd_word_d;
      full_q    <= full_d;
    end
  end

  // Row storage. A flush also drops a row that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_fire && !clear_i) begin
      mem_q[wr_sel_q][wr_row_q] <= row_data;
    end
  end

endmodule

// File: doc/mem_c_data_buffer.md
MEM_C_DATA_BUFFER -- requirements
Module: mem_c_data_buffer

Interface
REQ-001 Parameter BUS_WIDTH_BYTES, default 32, is the width of one write-bus word in bytes.
REQ-002 Parameter DATA_WIDTH_BYTES, default 2, is the size of one C element in bytes.
REQ-003 Parameter ARRAY_HEIGHT, default 4, is the number of result rows per tile (power of 2).
REQ-004 Parameter ARRAY_WIDTH, default 32, is the number of result elements per row (power of 2).
REQ-005 Derived constants: EPW = BUS_WIDTH_BYTES/DATA_WIDTH_BYTES elements per word; WPR = ARRAY_WIDTH/EPW words per row; TW = ARRAY_HEIGHT*WPR words per tile (defaults 16, 2, 8).
REQ-006 Port clk, input, 1: clock, rising edge.
REQ-007 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port clear_i, input, 1: synchronous flush, pulsed with the operation start.
REQ-009 Port row_valid, input, 1: row_data holds one valid result row.
REQ-010 Port row_ready, output, 1: buffer accepts a row this cycle.
REQ-011 Port row_data, input, ARRAY_WIDTH*DATA_WIDTH_BYTES*8: one result row; element j occupies bits [j*DW*8 +: DW*8].
REQ-012 Port fifo_empty, output, 1: no complete tile is available to drain.
REQ-013 Port fifo_incr, input, 1: pop the current output word.
REQ-014 Port data_o, output, BUS_WIDTH_BYTES*8: current output word (show-ahead).
REQ-015 Port tiles_held, output, 2: number of full tile slots (0..2).

Function
REQ-016 Storage SHALL be two tile slots (ping-pong), each ARRAY_HEIGHT rows by full row width, with per-slot full flag.
REQ-017 Write side: pointers wr_sel (1 bit) and wr_row (log2 ARRAY_HEIGHT bits); row_ready = ~full[wr_sel], driven from registered state only.
REQ-018 A row SHALL be accepted on a rising edge when row_valid & row_ready; it is stored into slot wr_sel row wr_row, and wr_row increments, wrapping to 0.
REQ-019 On accepting row ARRAY_HEIGHT-1, full[wr_sel] SHALL set and wr_sel SHALL toggle on the same edge; fifo_empty falls the following cycle (1-cycle latency).
REQ-020 Read side: pointers rd_sel (1 bit) and rd_word (log2 TW bits); fifo_empty = ~full[rd_sel].
REQ-021 Output ordering SHALL match the C address generator (row fastest, then column chunk): row = rd_word mod ARRAY_HEIGHT, chunk = rd_word / ARRAY_HEIGHT.
REQ-022 data_o SHALL combinationally equal bits [chunk*BUS_WIDTH_BYTES*8 +: BUS_WIDTH_BYTES*8] of slot rd_sel, row row.
REQ-023 fifo_incr with fifo_empty=0 SHALL increment rd_word; on word TW-1, rd_word wraps to 0, full[rd_sel] clears and rd_sel toggles.
REQ-024 fifo_incr while fifo_empty=1 SHALL be ignored (no pointer or flag change).
REQ-025 Simultaneous tile completion on write side and tile release on read side SHALL both take effect; tiles_held stays unchanged.
REQ-026 A slot freed on edge N SHALL be writable from cycle N+1; no same-cycle bypass from free to write.
REQ-027 row_valid while row_ready=0 SHALL be ignored; the upstream holds row_data until accepted.
REQ-028 tiles_held SHALL equal full[0]+full[1], registered-state derived.
REQ-029 clear_i SHALL zero all pointers and full flags on the next edge, overriding any same-cycle write or pop; slot data is not cleared.

Reset
REQ-030 On reset_n low: wr_sel, wr_row, rd_sel, rd_word, full[1:0] = 0; thus row_ready=1, fifo_empty=1, tiles_held=0.
REQ-031 Slot storage SHALL NOT be reset; data_o is don't-care while fifo_empty=1.
REQ-032 Reset asserted mid-tile SHALL discard partial tile and all held tiles immediately.

Verification
REQ-033 Defaults; load 4 rows with element(r,j)=r*32+j -> fifo_empty low 1 cycle after row 3; pop order words 0..7 = rows 0,1,2,3 cols 0-15, then rows 0,1,2,3 cols 16-31 (word0 element0=0x0000, word4 element0=0x0010, word7 element15=0x007F).
REQ-034 Load 2 tiles, no pops -> tiles_held=2, row_ready=0; extra row_valid ignored; pop 8 words -> row_ready=1 next cycle, tiles_held=1.
REQ-035 With tiles_held=1 and draining, complete a second tile on the same edge as the 8th pop -> tiles_held stays 1, fifo_empty stays 0, next data_o = tile2 word0.
REQ-036 fifo_incr pulses with fifo_empty=1 -> rd_word unchanged; first valid tile still starts at word0.
REQ-037 Load 2 rows, pop nothing, pulse clear_i (and separately reset_n) -> tiles_held=0, fifo_empty=1; next 4 rows form a complete tile starting at row 0.
REQ-038 Random row_valid/fifo_incr back-pressure over 50 tiles -> scoreboard matches REQ-021 order, no loss or duplication.
